// File: rtl/toggle_pulse_gen.sv
// rtl/toggle_pulse_gen.sv - debounced pushbutton front end producing one-cycle toggle requests
//
// Ports:
//   clk          in   system clock, all state updates on posedge
//   rst          in   synchronous active-high reset
//   btn_in       in   raw asynchronous, bouncing button
//   t            out  registered toggle request, one cycle high per accepted press
//   btn_stable   out  registered debounced button level
//   press_count  out  accepted presses, wraps modulo 2^CNT_W
module toggle_pulse_gen #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  output logic             t,
  output logic             btn_stable,
  output logic [CNT_W-1:0] press_count
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM_PRESS,
    HELD,
    ARM_REL
  } state_t;

  logic             s1, s2;
  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             t_n;
  logic             stable_n;
  logic [CNT_W-1:0] count_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      t           <= 1'b0;
      btn_stable  <= 1'b0;
      press_count <= '0;
    end else begin
      s1          <= btn_in;
      s2          <= s1;
      state       <= state_n;
      cnt         <= cnt_n;
      t           <= t_n;
      btn_stable  <= stable_n;
      press_count <= count_n;
    end
  end

  // Entering an ARM state already consumed one opposite sample, so the
  // counter reaching DB_CYCLES-1 means DB_CYCLES+1 consecutive samples.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    t_n      = 1'b0;
    stable_n = btn_stable;
    count_n  = press_count;
    case (state)
      IDLE: begin
        if (s2) begin
          state_n = ARM_PRESS;
          cnt_n   = '0;
        end
      end
      ARM_PRESS: begin
        if (!s2) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n  = HELD;
          t_n      = 1'b1;
          stable_n = 1'b1;
          count_n  = press_count + CNT_W'(1);
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!s2) begin
          state_n = ARM_REL;
          cnt_n   = '0;
        end
      end
      ARM_REL: begin
        if (s2) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n  = IDLE;
          stable_n = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: doc/toggle_pulse_gen.md
# toggle_pulse_gen

Debounced pushbutton front end that produces the `t` input for the negedge-clocked toggle flip-flop stage. It synchronizes a raw, bouncing button, confirms each press and release through a stable-sample counter, and emits exactly one single-cycle `t` pulse per accepted press. It also exports the debounced level and a wrapping press count for status LEDs and debug.

## Interface
- `DB_CYCLES`, 4: consecutive stable synchronized samples (after the first) required to accept a level change. Legal range is 2..255.
- `CNT_W`, 8: width of `press_count`.
- `clk`  in  1  system clock. All state updates on posedge.
- `rst`  in  1  synchronous, active-high reset, sampled on posedge `clk`.
- `btn_in`  in  1  raw button, asynchronous to `clk`, may bounce.
- `t`  out  1  registered toggle request, high for exactly one `clk` cycle per accepted press.
- `btn_stable`  out  1  registered debounced button level.
- `press_count`  out  CNT_W  number of accepted presses, modulo 2^CNT_W.

## Operation
- **Synchronizer:** two flops, `btn_in` -> `s1` -> `s2`. Only `s2` is used downstream.
- **Counter:** `cnt` is an internal debounce counter, width ceil(log2(DB_CYCLES)).
- **FSM states:** IDLE (stable low), ARM_PRESS, HELD (stable high), ARM_REL.
- **IDLE:** if `s2`=1, go to ARM_PRESS and set `cnt`<=0. Otherwise stay.
- **ARM_PRESS:**
  - If `s2`=0, return to IDLE, `cnt`<=0.
  - Else if `cnt`==DB_CYCLES-1, go to HELD with `t`<=1, `btn_stable`<=1, `press_count`<=`press_count`+1.
  - Else `cnt`<=`cnt`+1.
- **HELD:** if `s2`=0, go to ARM_REL and set `cnt`<=0.
- **ARM_REL:**
  - If `s2`=1, return to HELD, `cnt`<=0.
  - Else if `cnt`==DB_CYCLES-1, go to IDLE with `btn_stable`<=0.
  - Else `cnt`<=`cnt`+1.
  - Release never pulses `t`.
- **`t` default:** `t`<=0 on every cycle not listed above. `t` can never be high on two consecutive cycles.
- **Count wrap:** `press_count` wraps from 2^CNT_W-1 to 0. The `t` pulse is issued normally on the wrapping press.
- **Bounce:** any single-sample glitch during ARM_PRESS or ARM_REL restarts from the stable state. No pulse is lost or duplicated.

## Timing
- **Reset values:** while `rst` is high at a posedge, the next values are `s1`=`s2`=0, state=IDLE, `cnt`=0, `t`=0, `btn_stable`=0, `press_count`=0. `rst` overrides all other activity.
- **Reset mid-operation:** reset during ARM_PRESS or ARM_REL discards progress with no pulse. If the button is held through reset, it is re-qualified as a new press after reset deasserts, and a pulse is issued.
- **Press latency:** `btn_in` goes high before posedge k and stays stable. Then `s2`=1 after edge k+1, ARM_PRESS is entered at edge k+2, and `t`, `btn_stable` and the count increment all update at edge k+DB_CYCLES+2. `t` is low again after edge k+DB_CYCLES+3.
  - DB_CYCLES=4 gives `t` high in the cycle after edge k+6.
- **Release latency:** the same, DB_CYCLES+2 edges until `btn_stable` falls.
- **Minimum accepted press width:** DB_CYCLES+1 consecutive high samples of `s2`.
- **Handoff to the toggle flip-flop:** `t` changes only on posedge and is held a full cycle. The downstream negedge samples it mid-cycle, exactly once per pulse.

## Test plan
- **Reset:** assert `rst` 3 cycles with `btn_in`=1, then release. Outputs are 0 during reset. One `t` pulse appears 6 edges after the first post-reset capture edge (DB_CYCLES=4), and `press_count`=1.
- **Clean press/release:** hold `btn_in` high 20 cycles, then low 20 cycles. Exactly one `t` pulse of width 1. `btn_stable` rises with `t`, falls 6 edges after release capture, `press_count`=1.
- **Bounce:** toggle `btn_in` every cycle for 8 cycles, then hold high. No pulse during the bounce. Exactly one pulse DB_CYCLES+2 edges after the final rising capture.
- **Short glitch:** hold `btn_in` high 4 cycles, then low 20 cycles. No `t` pulse, `btn_stable` stays 0, `press_count` stays 0.
- **Wrap:** CNT_W=2, perform 5 clean presses. `press_count` sequence 1,2,3,0,1, with 5 `t` pulses.
- **Integration with the toggle flip-flop:** starting from its q=1, 3 presses leave q=0, and each q change occurs on the negedge inside a `t`-high cycle.
